// File: rtl/ex_result_stage.sv
// Execute-result register stage: captures ALU outputs, selects the writeback value,
// turns trapping overflow into a precise exception and buffers results in a 2-entry skid.
module ex_result_stage #(
    parameter int TRAPCNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          aluout,
    input  logic                 compout,
    input  logic                 overflow,
    input  logic                 in_selcomp,
    input  logic                 in_trapov,
    input  logic                 in_regwrite,
    input  logic [4:0]           in_rd,
    input  logic [31:0]          in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [4:0]           out_rd,
    output logic                 out_regwrite,
    input  logic                 flush,
    output logic                 exc_pending,
    output logic [31:0]          exc_pc,
    input  logic                 exc_ack,
    output logic [TRAPCNT_W-1:0] trap_count
);

    logic                 head_vld_q, head_vld_d;
    logic [31:0]          head_data_q, head_data_d;
    logic [4:0]           head_rd_q, head_rd_d;
    logic                 head_we_q, head_we_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [31:0]          skid_data_q, skid_data_d;
    logic [4:0]           skid_rd_q, skid_rd_d;
    logic                 skid_we_q, skid_we_d;
    logic                 in_ready_q, in_ready_d;
    logic                 exc_pending_q, exc_pending_d;
    logic [31:0]          exc_pc_q, exc_pc_d;
    logic [TRAPCNT_W-1:0] trap_cnt_q, trap_cnt_d;

    logic        accept, trap, squash, push, pop;
    logic [31:0] wb_data;
    logic        wb_we;

    always_comb begin
        accept  = in_valid && in_ready_q;
        // A flushed acceptance is dropped before any trap check.
        trap    = accept && !flush && in_trapov && overflow && !exc_pending_q;
        squash  = accept && exc_pending_q;
        push    = accept && !flush && !trap && !squash;
        pop     = head_vld_q && out_ready;
        wb_data = in_selcomp ? {31'b0, compout} : aluout;
        wb_we   = in_regwrite && (in_rd != 5'd0);
    end

    always_comb begin
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;
        head_rd_d   = head_rd_q;
        head_we_d   = head_we_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_rd_d   = skid_rd_q;
        skid_we_d   = skid_we_q;
        in_ready_d  = in_ready_q;

        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            in_ready_d = 1'b1;
        end else if (!head_vld_q) begin
            if (push) begin
                head_vld_d  = 1'b1;
                head_data_d = wb_data;
                head_rd_d   = in_rd;
                head_we_d   = wb_we;
            end
        end else if (!skid_vld_q) begin
            if (push && !pop) begin
                skid_vld_d  = 1'b1;
                skid_data_d = wb_data;
                skid_rd_d   = in_rd;
                skid_we_d   = wb_we;
                in_ready_d  = 1'b0;
            end else if (push && pop) begin
                head_data_d = wb_data;
                head_rd_d   = in_rd;
                head_we_d   = wb_we;
            end else if (pop) begin
                head_vld_d = 1'b0;
            end
        end else if (pop) begin
            // in_ready is low whenever the skid is full, so no push can occur here.
            head_data_d = skid_data_q;
            head_rd_d   = skid_rd_q;
            head_we_d   = skid_we_q;
            skid_vld_d  = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_comb begin
        exc_pending_d = exc_pending_q;
        exc_pc_d      = exc_pc_q;
        trap_cnt_d    = trap_cnt_q;
        if (exc_ack) begin
            exc_pending_d = 1'b0;
        end
        if (trap) begin
            exc_pending_d = 1'b1;
            exc_pc_d      = in_pc;
            if (trap_cnt_q != {TRAPCNT_W{1'b1}}) begin
                trap_cnt_d = trap_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_vld_q    <= 1'b0;
            head_data_q   <= 32'd0;
            head_rd_q     <= 5'd0;
            head_we_q     <= 1'b0;
            skid_vld_q    <= 1'b0;
            skid_data_q   <= 32'd0;
            skid_rd_q     <= 5'd0;
            skid_we_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            exc_pending_q <= 1'b0;
            exc_pc_q      <= 32'd0;
            trap_cnt_q    <= '0;
        end else begin
            head_vld_q    <= head_vld_d;
            head_data_q   <= head_data_d;
            head_rd_q     <= head_rd_d;
            head_we_q     <= head_we_d;
            skid_vld_q    <= skid_vld_d;
            skid_data_q   <= skid_data_d;
            skid_rd_q     <= skid_rd_d;
            skid_we_q     <= skid_we_d;
            in_ready_q    <= in_ready_d;
            exc_pending_q <= exc_pending_d;
            exc_pc_q      <= exc_pc_d;
            trap_cnt_q    <= trap_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = head_vld_q;
    assign out_data     = head_data_q;
    assign out_rd       = head_rd_q;
    assign out_regwrite = head_we_q;
    assign exc_pending  = exc_pending_q;
    assign exc_pc       = exc_pc_q;
    assign trap_count   = trap_cnt_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: stimulus queues expected writebacks, a monitor
// pops and compares on every output handshake; status outputs are checked directly.
module tb_ex_result_stage;

    localparam int TW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   aluout = 32'd0;
    logic          compout = 1'b0;
    logic          overflow = 1'b0;
    logic          in_selcomp = 1'b0;
    logic          in_trapov = 1'b0;
    logic          in_regwrite = 1'b0;
    logic [4:0]    in_rd = 5'd0;
    logic [31:0]   in_pc = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_data;
    logic [4:0]    out_rd;
    logic          out_regwrite;
    logic          flush = 1'b0;
    logic          exc_pending;
    logic [31:0]   exc_pc;
    logic          exc_ack = 1'b0;
    logic [TW-1:0] trap_count;

    int checks = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    ex_result_stage #(.TRAPCNT_W(TW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluout(aluout), .compout(compout), .overflow(overflow),
        .in_selcomp(in_selcomp), .in_trapov(in_trapov), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .flush(flush), .exc_pending(exc_pending), .exc_pc(exc_pc),
        .exc_ack(exc_ack), .trap_count(trap_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic comp, input logic ov,
                         input logic sel, input logic tov, input logic we,
                         input logic [4:0] rd, input logic [31:0] pc);
        in_valid    = 1'b1;
        aluout      = alu;
        compout     = comp;
        overflow    = ov;
        in_selcomp  = sel;
        in_trapov   = tov;
        in_regwrite = we;
        in_rd       = rd;
        in_pc       = pc;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        overflow  = 1'b0;
        in_trapov = 1'b0;
    endtask

    task automatic expect_wb(input logic [31:0] data, input logic [4:0] rd, input logic we);
        exp_q.push_back({we, rd, data});
    endtask

    // Monitor: compare every completed output handshake against the scoreboard.
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got data=0x%08h rd=%0d we=%0b, expected none",
                             out_data, out_rd, out_regwrite);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_regwrite, out_rd, out_data} !== e) begin
                        failures++;
                        $display("FAIL wb_entry: got data=0x%08h rd=%0d we=%0b expected data=0x%08h rd=%0d we=%0b",
                                 out_data, out_rd, out_regwrite, e[31:0], e[36:32], e[37]);
                    end
                end
            end
        end
    end

    initial begin
        // Reset values
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_rd", {27'b0, out_rd}, 32'd0);
        check("rst_out_regwrite", {31'b0, out_regwrite}, 32'd0);
        check("rst_exc_pending", {31'b0, exc_pending}, 32'd0);
        check("rst_exc_pc", exc_pc, 32'd0);
        check("rst_trap_count", {30'b0, trap_count}, 32'd0);
        reset = 1'b0;
        step();

        // Single SLT
        out_ready = 1'b1;
        drive(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0040_0000);
        expect_wb(32'h1, 5'd8, 1'b1);
        step();
        idle();
        check("slt_out_valid", {31'b0, out_valid}, 32'd1);
        check("slt_out_data", out_data, 32'h1);
        step();
        check("slt_drained", {31'b0, out_valid}, 32'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0040_0004);
        expect_wb(32'h11, 5'd1, 1'b1);
        step();
        drive(32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0040_0008);
        expect_wb(32'h22, 5'd2, 1'b1);
        step();
        idle();
        check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        check("bp_hold_data", out_data, 32'h11);
        step();
        check("bp_hold_data2", out_data, 32'h11);
        check("bp_hold_rd", {27'b0, out_rd}, 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_in_ready_after_pop", {31'b0, in_ready}, 32'd1);
        check("bp_second", out_data, 32'h22);
        step();
        check("bp_empty", {31'b0, out_valid}, 32'd0);

        // Unsigned overflow is enqueued, no trap
        drive(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0040_000c);
        expect_wb(32'h8000_0000, 5'd3, 1'b1);
        step();
        idle();
        check("addu_no_trap", {31'b0, exc_pending}, 32'd0);
        step();

        // Trap and squash
        drive(32'h7fff_ffff, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0040_0010);
        step();
        drive(32'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10, 32'h0040_0014);
        check("trap_pending", {31'b0, exc_pending}, 32'd1);
        check("trap_pc", exc_pc, 32'h0040_0010);
        check("trap_count1", {30'b0, trap_count}, 32'd1);
        check("trap_no_out", {31'b0, out_valid}, 32'd0);
        step();
        idle();
        check("squash_pc_hold", exc_pc, 32'h0040_0010);
        check("squash_no_out", {31'b0, out_valid}, 32'd0);
        exc_ack = 1'b1;
        step();
        exc_ack = 1'b0;
        check("ack_clears", {31'b0, exc_pending}, 32'd0);

        // Saturation
        for (int i = 0; i < 5; i++) begin
            drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0040_0100 + 32'(i * 4));
            step();
            idle();
            exc_ack = 1'b1;
            step();
            exc_ack = 1'b0;
        end
        check("sat_count", {30'b0, trap_count}, 32'd3);
        check("sat_pending", {31'b0, exc_pending}, 32'd0);
        check("sat_exc_pc", exc_pc, 32'h0040_0110);

        // Ack coinciding with a trapping acceptance while pending
        drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0040_0200);
        step();
        drive(32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0040_0204);
        exc_ack = 1'b1;
        step();
        idle();
        exc_ack = 1'b0;
        check("ack_coincide_pending", {31'b0, exc_pending}, 32'd0);
        check("ack_coincide_pc", exc_pc, 32'h0040_0200);
        check("ack_coincide_no_out", {31'b0, out_valid}, 32'd0);

        // Flush while full
        out_ready = 1'b0;
        drive(32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0040_0300);
        step();
        drive(32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0040_0304);
        step();
        check("flush_pre_full", {31'b0, in_ready}, 32'd0);
        drive(32'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0040_0308);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);

        // Flush with a same-cycle acceptance into the head-only state
        drive(32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0040_030c);
        step();
        drive(32'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h0040_0310);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("flush_accept_dropped", {31'b0, out_valid}, 32'd0);
        check("flush_no_trap", {31'b0, exc_pending}, 32'd0);
        out_ready = 1'b1;
        step();
        step();

        // Reset mid-operation
        out_ready = 1'b0;
        drive(32'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0040_0400);
        step();
        idle();
        check("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_valid", {31'b0, out_valid}, 32'd0);
        check("reset_async_data", out_data, 32'd0);
        check("reset_async_count", {30'b0, trap_count}, 32'd0);
        #3;
        reset = 1'b0;
        step();

        // rd = 0 suppresses write enable
        out_ready = 1'b1;
        drive(32'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0040_0500);
        expect_wb(32'h5, 5'd0, 1'b0);
        step();
        idle();
        check("rd0_regwrite", {31'b0, out_regwrite}, 32'd0);
        check("rd0_data", out_data, 32'h5);
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
